// File: rtl/spatz_tcdm_pkg.sv
// Shared types for the TCDM bank endpoint: AMO opcodes, bank FSM states
// and the AMO operand width.
package spatz_tcdm_pkg;

    localparam int unsigned AmoWidth = 32;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MAXU = 4'd7,
        AMO_MIN  = 4'd8,
        AMO_MINU = 4'd9
    } amo_op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        AMO_WB = 1'b1
    } bank_state_e;

    // Opcodes 10..15 are reserved and behave like NONE.
    function automatic logic is_amo(logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd9);
    endfunction

endpackage

// File: rtl/spatz_tcdm_bank_responder_amo_alu.sv
// Combinational 32-bit AMO ALU: result = op(old_i, operand_i).
// Ports: op_i (amo_op_e encoding), old_i, operand_i, result_o.
module spatz_amo_alu
    import spatz_tcdm_pkg::*;
(
    input  logic [3:0]          op_i,
    input  logic [AmoWidth-1:0] old_i,
    input  logic [AmoWidth-1:0] operand_i,
    output logic [AmoWidth-1:0] result_o
);

    always_comb begin
        result_o = old_i;
        case (amo_op_e'(op_i))
            AMO_SWAP: result_o = operand_i;
            AMO_ADD:  result_o = old_i + operand_i;
            AMO_AND:  result_o = old_i & operand_i;
            AMO_OR:   result_o = old_i | operand_i;
            AMO_XOR:  result_o = old_i ^ operand_i;
            AMO_MAX:  result_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            AMO_MAXU: result_o = (old_i > operand_i) ? old_i : operand_i;
            AMO_MIN:  result_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            AMO_MINU: result_o = (old_i < operand_i) ? old_i : operand_i;
            default:  result_o = old_i;
        endcase
    end

endmodule

// File: rtl/spatz_tcdm_bank_responder.sv
// One TCDM bank: storage, fixed-latency response pipeline, AMO read-modify-write.
// Ports: clk_i/rst_i, request q_* (valid/ready, addr, write, amo, data, strb,
// user), response p_* (valid, data, user) with no backpressure.
module spatz_tcdm_bank_responder
    import spatz_tcdm_pkg::*;
#(
    parameter int unsigned NumWords  = 512,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned UserWidth = 1,
    parameter int unsigned Latency   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [AddrWidth-1:0]   q_addr_i,
    input  logic                   q_write_i,
    input  logic [3:0]             q_amo_i,
    input  logic [DataWidth-1:0]   q_data_i,
    input  logic [DataWidth/8-1:0] q_strb_i,
    input  logic [UserWidth-1:0]   q_user_i,
    output logic                   p_valid_o,
    output logic [DataWidth-1:0]   p_data_o,
    output logic [UserWidth-1:0]   p_user_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [NumWords];

    bank_state_e          state_q, state_d;
    logic                 ready_q, ready_d;
    logic [AddrWidth-1:0] wb_addr_q, wb_addr_d;
    logic [AmoWidth-1:0]  wb_operand_q, wb_operand_d;
    logic                 wb_lane_q, wb_lane_d;
    logic [DataWidth-1:0] wb_old_q, wb_old_d;
    logic [3:0]           wb_op_q, wb_op_d;

    logic                 pipe_valid_q [Latency];
    logic                 pipe_valid_d [Latency];
    logic [DataWidth-1:0] pipe_data_q  [Latency];
    logic [DataWidth-1:0] pipe_data_d  [Latency];
    logic [UserWidth-1:0] pipe_user_q  [Latency];
    logic [UserWidth-1:0] pipe_user_d  [Latency];

    logic                 accept;
    logic                 req_amo;
    logic                 wr_we;
    logic                 wb_we;
    logic [DataWidth-1:0] rd_word;
    logic [DataWidth-1:0] wr_word;
    logic [DataWidth-1:0] wb_word;
    logic                 q_lane;
    logic [AmoWidth-1:0]  q_operand;
    logic [AmoWidth-1:0]  wb_old_lane;
    logic [AmoWidth-1:0]  alu_result;

    assign q_ready_o = ready_q;
    assign accept    = q_valid_i & ready_q;
    assign req_amo   = is_amo(q_amo_i);
    assign rd_word   = mem_q[q_addr_i];
    assign wr_we     = accept & ~req_amo & q_write_i;
    assign wb_we     = (state_q == AMO_WB);

    // Lane selection only exists for 64-bit words; strb[4] picks the upper half.
    if (DataWidth == 64) begin : g_wide
        assign q_lane      = q_strb_i[4];
        assign q_operand   = q_strb_i[4] ? q_data_i[63:32] : q_data_i[31:0];
        assign wb_old_lane = wb_lane_q ? wb_old_q[63:32] : wb_old_q[31:0];
        assign wb_word     = wb_lane_q ? {alu_result, wb_old_q[31:0]}
                                       : {wb_old_q[63:32], alu_result};
    end else begin : g_narrow
        assign q_lane      = 1'b0;
        assign q_operand   = q_data_i[31:0];
        assign wb_old_lane = wb_old_q[31:0];
        assign wb_word     = alu_result;
    end

    spatz_amo_alu i_amo_alu (
        .op_i      (wb_op_q),
        .old_i     (wb_old_lane),
        .operand_i (wb_operand_q),
        .result_o  (alu_result)
    );

    always_comb begin
        wr_word = rd_word;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (q_strb_i[b]) wr_word[b*8 +: 8] = q_data_i[b*8 +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        wb_addr_d    = wb_addr_q;
        wb_operand_d = wb_operand_q;
        wb_lane_d    = wb_lane_q;
        wb_old_d     = wb_old_q;
        wb_op_d      = wb_op_q;
        unique case (state_q)
            IDLE: begin
                if (accept && req_amo) begin
                    state_d      = AMO_WB;
                    ready_d      = 1'b0;
                    wb_addr_d    = q_addr_i;
                    wb_operand_d = q_operand;
                    wb_lane_d    = q_lane;
                    wb_old_d     = rd_word;
                    wb_op_d      = q_amo_i;
                end
            end
            AMO_WB: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            wb_addr_q    <= '0;
            wb_operand_q <= '0;
            wb_lane_q    <= 1'b0;
            wb_old_q     <= '0;
            wb_op_q      <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            wb_addr_q    <= wb_addr_d;
            wb_operand_q <= wb_operand_d;
            wb_lane_q    <= wb_lane_d;
            wb_old_q     <= wb_old_d;
            wb_op_q      <= wb_op_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held so a
    // pending AMO write-back is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (wb_we) begin
                mem_q[wb_addr_q] <= wb_word;
            end else if (wr_we) begin
                mem_q[q_addr_i] <= wr_word;
            end
        end
    end

    // Every accept (read, write or AMO) returns the pre-access word.
    always_comb begin
        pipe_valid_d[0] = accept;
        pipe_data_d[0]  = accept ? rd_word : '0;
        pipe_user_d[0]  = accept ? q_user_i : '0;
        for (int unsigned i = 1; i < Latency; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
            pipe_user_d[i]  = pipe_user_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Latency; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_data_q[i]  <= '0;
                pipe_user_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Latency; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_data_q[i]  <= pipe_data_d[i];
                pipe_user_q[i]  <= pipe_user_d[i];
            end
        end
    end

    assign p_valid_o = pipe_valid_q[Latency-1];
    assign p_data_o  = pipe_data_q[Latency-1];
    assign p_user_o  = pipe_user_q[Latency-1];

endmodule

// File: tb/tb_spatz_tcdm_bank_responder.sv
// Self-checking bench for spatz_tcdm_bank_responder: directed table,
// random traffic against a reference model, reset during AMO write-back.
module tb_spatz_tcdm_bank_responder;

    localparam int NW  = 16;
    localparam int DW  = 64;
    localparam int AW  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          q_valid_i = 1'b0;
    logic          q_ready_o;
    logic [AW-1:0] q_addr_i = '0;
    logic          q_write_i = 1'b0;
    logic [3:0]    q_amo_i = '0;
    logic [DW-1:0] q_data_i = '0;
    logic [7:0]    q_strb_i = '0;
    logic [0:0]    q_user_i = '0;
    logic          p_valid_o;
    logic [DW-1:0] p_data_o;
    logic [0:0]    p_user_o;

    always #5 clk = ~clk;

    spatz_tcdm_bank_responder #(
        .NumWords  (NW),
        .DataWidth (DW),
        .AddrWidth (AW),
        .UserWidth (1),
        .Latency   (LAT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .q_valid_i (q_valid_i),
        .q_ready_o (q_ready_o),
        .q_addr_i  (q_addr_i),
        .q_write_i (q_write_i),
        .q_amo_i   (q_amo_i),
        .q_data_i  (q_data_i),
        .q_strb_i  (q_strb_i),
        .q_user_i  (q_user_i),
        .p_valid_o (p_valid_o),
        .p_data_o  (p_data_o),
        .p_user_o  (p_user_o)
    );

    // mode: 0 = data not checked, 1 = data from model, 2 = data from table
    typedef struct {
        bit          v;
        int          addr;
        bit          w;
        int          amo;
        logic [63:0] data;
        logic [7:0]  strb;
        bit          user;
        int          mode;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        bit          chk;
        logic [63:0] data;
        bit          user;
    } rsp_t;

    rsp_t        sb[$];
    logic [63:0] mem_m [NW];
    bit          m_ready;
    bit          m_wb;
    int          m_wb_addr;
    logic [63:0] m_wb_word;
    int          cyc;
    int          n_cmp;
    int          n_err;
    vec_t        tbl [26];

    function automatic vec_t mk(bit v, int addr, bit w, int amo, logic [63:0] d,
                                logic [7:0] s, bit u, int mode, logic [63:0] e);
        vec_t r;
        r.v = v; r.addr = addr; r.w = w; r.amo = amo; r.data = d;
        r.strb = s; r.user = u; r.mode = mode; r.exp = e;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 64'h0, 8'h0, 0, 0, 64'h0);
    endfunction

    // Reference AMO semantics on 32-bit lanes, via wide integer arithmetic.
    function automatic logic [31:0] amo_ref(int op, logic [31:0] a, logic [31:0] b);
        longint sa, sb_, ua, ub;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        case (op)
            1: return b;
            2: return 32'((ua + ub) % 64'h1_0000_0000);
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return (sa >= sb_) ? a : b;
            7: return (ua >= ub) ? a : b;
            8: return (sa <= sb_) ? a : b;
            9: return (ua <= ub) ? a : b;
            default: return a;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("p_valid", 64'(p_valid_o), 64'd1);
            check("p_user", 64'(p_user_o), 64'(sb[0].user));
            if (sb[0].chk) check("p_data", p_data_o, sb[0].data);
            void'(sb.pop_front());
        end else begin
            check("p_valid_idle", 64'(p_valid_o), 64'd0);
        end
    endtask

    task automatic run(input vec_t r);
        bit          acc;
        bit          amo;
        logic [63:0] old;
        logic [63:0] nw;
        logic [63:0] ev;
        rsp_t        e;
        int          lane;
        q_valid_i = r.v;
        q_addr_i  = r.addr[AW-1:0];
        q_write_i = r.w;
        q_amo_i   = r.amo[3:0];
        q_data_i  = r.data;
        q_strb_i  = r.strb;
        q_user_i  = r.user;
        #1;
        check("q_ready", 64'(q_ready_o), 64'(m_ready));
        acc = r.v && m_ready;
        amo = (r.amo >= 1) && (r.amo <= 9);
        old = mem_m[r.addr];
        if (acc) begin
            ev     = (r.mode == 2) ? r.exp : old;
            e.due  = cyc + LAT;
            e.chk  = (r.mode != 0);
            e.data = ev;
            e.user = r.user;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (m_wb) begin
            mem_m[m_wb_addr] = m_wb_word;
            m_wb    = 0;
            m_ready = 1;
        end
        if (acc && amo) begin
            lane = r.strb[4] ? 1 : 0;
            nw   = old;
            nw[lane*32 +: 32] = amo_ref(r.amo, old[lane*32 +: 32], r.data[lane*32 +: 32]);
            m_wb      = 1;
            m_ready   = 0;
            m_wb_addr = r.addr;
            m_wb_word = nw;
        end else if (acc && r.w) begin
            for (int b = 0; b < 8; b++)
                if (r.strb[b]) mem_m[r.addr][b*8 +: 8] = r.data[b*8 +: 8];
        end
        check_outputs();
    endtask

    initial begin
        vec_t r;
        n_cmp = 0; n_err = 0; cyc = 0;
        m_ready = 1; m_wb = 0; m_wb_addr = 0; m_wb_word = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_q_ready", 64'(q_ready_o), 64'd1);
        check("rst_p_valid", 64'(p_valid_o), 64'd0);
        check("rst_p_data", p_data_o, 64'd0);
        check("rst_p_user", 64'(p_user_o), 64'd0);
        rst_i = 1'b0;

        for (int i = 0; i < NW; i++) run(mk(1, i, 1, 0, 64'h0, 8'hFF, 0, 0, 64'h0));

        tbl[0]  = mk(1, 5, 1, 0, 64'h1122334455667788, 8'hFF, 0, 2, 64'h0);
        tbl[1]  = mk(1, 5, 0, 0, 64'h0, 8'h00, 1, 2, 64'h1122334455667788);
        tbl[2]  = mk(1, 7, 1, 0, 64'hAAAAAAAABBBBBBBB, 8'hFF, 0, 2, 64'h0);
        tbl[3]  = mk(1, 7, 1, 0, 64'h0000000000000001, 8'h0F, 1, 2, 64'hAAAAAAAABBBBBBBB);
        tbl[4]  = mk(1, 7, 0, 0, 64'h0, 8'h00, 0, 2, 64'hAAAAAAAA00000001);
        tbl[5]  = mk(1, 3, 1, 0, 64'h000000007FFFFFFF, 8'hFF, 0, 2, 64'h0);
        tbl[6]  = mk(1, 3, 0, 2, 64'h0000000000000001, 8'h0F, 1, 2, 64'h000000007FFFFFFF);
        tbl[7]  = idle();
        tbl[8]  = mk(1, 3, 0, 0, 64'h0, 8'h00, 0, 2, 64'h0000000080000000);
        tbl[9]  = mk(1, 9, 1, 0, 64'hFFFFFFFF00000000, 8'hFF, 0, 2, 64'h0);
        tbl[10] = mk(1, 9, 0, 6, 64'h0, 8'hF0, 1, 2, 64'hFFFFFFFF00000000);
        tbl[11] = idle();
        tbl[12] = mk(1, 9, 0, 0, 64'h0, 8'h00, 0, 2, 64'h0);
        tbl[13] = mk(1, 9, 1, 0, 64'hFFFFFFFF00000000, 8'hFF, 1, 2, 64'h0);
        tbl[14] = mk(1, 9, 0, 7, 64'h0, 8'hF0, 0, 2, 64'hFFFFFFFF00000000);
        tbl[15] = idle();
        tbl[16] = mk(1, 9, 0, 0, 64'h0, 8'h00, 1, 2, 64'hFFFFFFFF00000000);
        tbl[17] = mk(1, 10, 1, 12, 64'h5, 8'hFF, 0, 2, 64'h0);
        tbl[18] = mk(1, 0, 0, 0, 64'h0, 8'h00, 0, 2, 64'h0);
        tbl[19] = mk(1, 1, 0, 0, 64'h0, 8'h00, 1, 2, 64'h0);
        tbl[20] = mk(1, 2, 0, 0, 64'h0, 8'h00, 0, 2, 64'h0);
        tbl[21] = mk(1, 3, 0, 0, 64'h0, 8'h00, 1, 2, 64'h0000000080000000);
        tbl[22] = mk(1, 10, 0, 0, 64'h0, 8'h00, 1, 2, 64'h5);
        tbl[23] = mk(1, 10, 0, 9, 64'h3, 8'h0F, 0, 2, 64'h5);
        tbl[24] = idle();
        tbl[25] = mk(1, 10, 0, 0, 64'h0, 8'h00, 1, 2, 64'h3);
        for (int i = 0; i < 26; i++) run(tbl[i]);

        for (int i = 0; i < 400; i++) begin
            r.v    = ($urandom_range(0, 3) != 0);
            r.addr = $urandom_range(0, NW - 1);
            r.w    = $urandom_range(0, 1) != 0;
            r.amo  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            r.data = {$urandom, $urandom};
            r.strb = 8'($urandom);
            r.user = $urandom_range(0, 1) != 0;
            r.mode = 1;
            r.exp  = '0;
            run(r);
        end
        repeat (LAT + 1) run(idle());

        run(mk(1, 11, 1, 0, 64'h0000000000001234, 8'hFF, 0, 0, 64'h0));
        run(mk(1, 11, 0, 1, 64'h000000000000DEAD, 8'h0F, 1, 0, 64'h0));
        q_valid_i = 1'b0;
        rst_i = 1'b1;
        #2;
        check("amo_rst_p_valid", 64'(p_valid_o), 64'd0);
        check("amo_rst_q_ready", 64'(q_ready_o), 64'd1);
        sb.delete();
        m_wb    = 0;
        m_ready = 1;
        @(posedge clk);
        #1;
        cyc++;
        check("amo_rst_hold_valid", 64'(p_valid_o), 64'd0);
        rst_i = 1'b0;
        run(mk(1, 11, 0, 0, 64'h0, 8'h00, 1, 2, 64'h0000000000001234));
        repeat (LAT + 1) run(idle());
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
